// File: rtl/test_sequencer.sv
// -----------------------------------------------------------------------------
// test_sequencer
//   Self-contained, synthesizable test sequencer that sits between the board
//   clock/reset and a DUT. On a start pulse it runs this sequence:
//     1. wait PRE_CYCLES,
//     2. drive a RST_CYCLES-long reset pulse into the DUT,
//     3. run the DUT for RUN_CYCLES, compressing its output bus into a MISR,
//     4. compare the final signature with EXPECTED_SIG and report pass/fail.
//
//   Optional feature macro: TESTSEQ_LOOP_EN
//     When defined, a passing run returns to PRE one cycle after DONE, which
//     gives continuous regression. A failing run stays latched until iStart.
//     When undefined, DONE always waits for iStart.
//
// Ports
//   Clock        in   system clock, rising edge
//   Reset        in   asynchronous active-high reset of this block
//   iStart       in   single-cycle start request (honoured in IDLE/DONE only)
//   iObserved    in   DUT output bus compressed into the MISR
//   oDutReset    out  registered active-high reset to the DUT (high in RST)
//   oBusy        out  high in PRE, RST and RUN
//   oDone        out  high in DONE
//   oPass        out  signature match, valid while oDone is high
//   oSignature   out  current MISR value
//   oCycleCount  out  number of RUN samples taken
// -----------------------------------------------------------------------------
module test_sequencer #(
  parameter int              DATA_W       = 8,
  parameter int              SIG_W        = 16,
  parameter logic [SIG_W-1:0] SIG_POLY    = 16'h1021,
  parameter logic [SIG_W-1:0] EXPECTED_SIG = 16'h0000,
  parameter int              PRE_CYCLES   = 10,
  parameter int              RST_CYCLES   = 5,
  parameter int              RUN_CYCLES   = 65,
  parameter int              CNT_W        = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iStart,
  input  logic [DATA_W-1:0] iObserved,
  output logic              oDutReset,
  output logic              oBusy,
  output logic              oDone,
  output logic              oPass,
  output logic [SIG_W-1:0]  oSignature,
  output logic [CNT_W-1:0]  oCycleCount
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_RST  = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [SIG_W-1:0]   sig_q,   sig_d;
  logic               pass_q,  pass_d;
  logic               done_q,  done_d;
  logic               busy_q,  busy_d;
  logic               dutrst_q, dutrst_d;

  logic [SIG_W-1:0]   misr_next;
  logic               start;

  // Galois-style MISR step: shift left, fold MSB through the polynomial,
  // then xor in the zero-extended observed bus.
  always_comb begin
    misr_next = {sig_q[SIG_W-2:0], 1'b0}
              ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
              ^ SIG_W'(iObserved);
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    start   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iStart) start = 1'b1;
      end
      S_PRE: begin
        if (phase_q == PRE_LAST) begin
          state_d = S_RST;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_RST: begin
        if (phase_q == RST_LAST) begin
          state_d = S_RUN;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_RUN: begin
        // The first RUN edge is the one on which oDutReset is seen low, so
        // the first sample is the DUT's first cycle out of reset.
        sig_d = misr_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RUN_LAST) begin
          state_d = S_DONE;
          pass_d  = (misr_next == EXPECTED_SIG);
        end
      end
      S_DONE: begin
`ifdef TESTSEQ_LOOP_EN
        if (iStart || pass_q) start = 1'b1;
`else
        if (iStart) start = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Entry to PRE: reseed MISR, clear run counter and result.
    if (start) begin
      state_d = S_PRE;
      phase_d = '0;
      cnt_d   = '0;
      sig_d   = '1;
      pass_d  = 1'b0;
    end

    // Status outputs are decoded from the next state so they are registered
    // and line up with the state they describe.
    busy_d   = (state_d == S_PRE) || (state_d == S_RST) || (state_d == S_RUN);
    done_d   = (state_d == S_DONE);
    dutrst_d = (state_d == S_RST);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      cnt_q    <= '0;
      sig_q    <= '0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      dutrst_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      sig_q    <= sig_d;
      pass_q   <= pass_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      dutrst_q <= dutrst_d;
    end
  end

  assign oDutReset   = dutrst_q;
  assign oBusy       = busy_q;
  assign oDone       = done_q;
  assign oPass       = pass_q;
  assign oSignature  = sig_q;
  assign oCycleCount = cnt_q;

endmodule
